// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the multi-channel SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;

    localparam int MODE_SEL  = 0;
    localparam int MODE_RR   = 1;
    localparam int MODE_PRIO = 2;

    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot combinational grant: rotating (starts after ptr) or fixed lowest-index priority.
module rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    input  logic [1:0]        mode,
    output logic [NUM_CH-1:0] gnt
);

    logic found;
    int   j;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        j     = 0;
        if (mode == 2'(MODE_RR)) begin
            // Search starts one past the last owner so it gets lowest precedence.
            for (int i = 1; i <= NUM_CH; i++) begin
                j = (int'(ptr) + i) % NUM_CH;
                if (!found && req[IDX_W'(j)]) begin
                    gnt[IDX_W'(j)] = 1'b1;
                    found          = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!found && req[i]) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sram_arb_multi.sv
// NUM_CH Avalon-MM masters onto one asynchronous SRAM with wait states and a turnaround cycle.
module sram_arb_multi
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CH      = 4,
    parameter int SEL_WIDTH   = 2,
    parameter int MODE        = 1,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [SEL_WIDTH-1:0]           sel,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   m_address,
    input  logic [NUM_CH*DATA_WIDTH/8-1:0] m_byteenable,
    input  logic [NUM_CH-1:0]              m_read,
    input  logic [NUM_CH-1:0]              m_write,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   m_writedata,
    output logic [NUM_CH-1:0]              m_waitrequest,
    output logic [DATA_WIDTH-1:0]          m_readdata,
    output logic [NUM_CH-1:0]              m_readdatavalid,
    output logic [NUM_CH-1:0]              grant,
    output logic [ADDR_WIDTH-1:0]          sram_address,
    inout  wire  [DATA_WIDTH-1:0]          sram_data,
    output logic                           sram_ce_n,
    output logic                           sram_oe_n,
    output logic                           sram_we_n,
    output logic [DATA_WIDTH/8-1:0]        sram_be_n
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = clog2(NUM_CH);

    logic [NUM_CH-1:0][ADDR_WIDTH-1:0] ch_addr;
    logic [NUM_CH-1:0][BE_W-1:0]       ch_be;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] ch_wdata;

    assign ch_addr  = m_address;
    assign ch_be    = m_byteenable;
    assign ch_wdata = m_writedata;

    state_t                state, state_nxt;
    logic [3:0]            cnt;
    logic [IDX_W-1:0]      owner, rr_ptr, pick_idx;
    logic                  op_wr;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BE_W-1:0]       be_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [NUM_CH-1:0]     grant_q, req, elig, arb_gnt;
    logic                  ch_hit, acc_done;

    assign req = m_read | m_write;

    rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arb (
        .req  (req),
        .ptr  (rr_ptr),
        .mode (2'(MODE)),
        .gnt  (arb_gnt)
    );

    // Sel mode bypasses the arbiter; an out-of-range sel matches no channel.
    always_comb begin
        elig     = '0;
        pick_idx = '0;
        if (MODE == MODE_SEL) begin
            for (int i = 0; i < NUM_CH; i++)
                elig[i] = req[i] && (int'(sel) == i);
        end else begin
            elig = arb_gnt;
        end
        for (int i = 0; i < NUM_CH; i++)
            if (elig[i]) pick_idx = IDX_W'(i);
    end

    assign ch_hit   = |elig;
    assign acc_done = (state == ACCESS) && (cnt == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ch_hit) state_nxt = ACCESS;
            ACCESS:  if (cnt == '0) state_nxt = TURN;
            TURN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            owner   <= '0;
            op_wr   <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            grant_q <= '0;
            rr_ptr  <= IDX_W'(NUM_CH - 1);
        end else begin
            case (state)
                IDLE: if (ch_hit) begin
                    owner   <= pick_idx;
                    op_wr   <= m_write[pick_idx];
                    addr_q  <= ch_addr[pick_idx];
                    be_q    <= ch_be[pick_idx];
                    wdata_q <= ch_wdata[pick_idx];
                    grant_q <= elig;
                    cnt     <= 4'(WAIT_CYCLES);
                end
                ACCESS: begin
                    if (cnt != '0) cnt <= cnt - 4'd1;
                    else if (!op_wr) rdata_q <= sram_data;
                end
                TURN: begin
                    grant_q <= '0;
                    if (MODE == MODE_RR) rr_ptr <= owner;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        m_waitrequest   = '1;
        m_readdatavalid = '0;
        if (acc_done) m_waitrequest[owner] = 1'b0;
        if (state == TURN && !op_wr) m_readdatavalid[owner] = 1'b1;
    end

    // Address holds through TURN so the SRAM sees stable pins while controls rise.
    assign sram_ce_n    = !(state == ACCESS);
    assign sram_oe_n    = !(state == ACCESS && !op_wr);
    assign sram_we_n    = !(state == ACCESS && op_wr);
    assign sram_be_n    = (state == IDLE) ? '1 : ~be_q;
    assign sram_address = addr_q;
    assign sram_data    = (state == ACCESS && op_wr) ? wdata_q : 'z;
    assign m_readdata   = rdata_q;
    assign grant        = grant_q;

endmodule

// File: tb/tb_sram_arb_multi.sv
// Directed bench: RR, priority and sel-mode instances share master stimulus; 3-channel sel instance for out-of-range sel.
module tb_sram_arb_multi;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  sel;
    logic [79:0] m_address;
    logic [7:0]  m_byteenable;
    logic [3:0]  m_read, m_write;
    logic [63:0] m_writedata;

    wire  [15:0] sd_rr, sd_pr, sd_s4, sd_s3;
    logic [3:0]  wr_rr, rdv_rr, gnt_rr, wr_pr, rdv_pr, gnt_pr, wr_s4, rdv_s4, gnt_s4;
    logic [2:0]  wr_s3, rdv_s3, gnt_s3;
    logic [15:0] rd_rr, rd_pr, rd_s4, rd_s3;
    logic [19:0] addr_rr, addr_pr, addr_s4, addr_s3;
    logic        ce_rr, oe_rr, we_rr, ce_pr, oe_pr, we_pr, ce_s4, oe_s4, we_s4, ce_s3, oe_s3, we_s3;
    logic [1:0]  be_rr, be_pr, be_s4, be_s3;

    int n_vec = 0;
    int n_bad = 0;
    logic [15:0] mem [0:63];

    always #5 clock = ~clock;

    sram_arb_multi #(.NUM_CH(4), .MODE(1), .WAIT_CYCLES(1)) u_rr (
        .clock(clock), .reset_n(reset_n), .sel(sel), .m_address(m_address),
        .m_byteenable(m_byteenable), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_waitrequest(wr_rr), .m_readdata(rd_rr),
        .m_readdatavalid(rdv_rr), .grant(gnt_rr), .sram_address(addr_rr),
        .sram_data(sd_rr), .sram_ce_n(ce_rr), .sram_oe_n(oe_rr), .sram_we_n(we_rr),
        .sram_be_n(be_rr));

    sram_arb_multi #(.NUM_CH(4), .MODE(2), .WAIT_CYCLES(1)) u_pr (
        .clock(clock), .reset_n(reset_n), .sel(sel), .m_address(m_address),
        .m_byteenable(m_byteenable), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_waitrequest(wr_pr), .m_readdata(rd_pr),
        .m_readdatavalid(rdv_pr), .grant(gnt_pr), .sram_address(addr_pr),
        .sram_data(sd_pr), .sram_ce_n(ce_pr), .sram_oe_n(oe_pr), .sram_we_n(we_pr),
        .sram_be_n(be_pr));

    sram_arb_multi #(.NUM_CH(4), .MODE(0), .WAIT_CYCLES(1)) u_s4 (
        .clock(clock), .reset_n(reset_n), .sel(sel), .m_address(m_address),
        .m_byteenable(m_byteenable), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_waitrequest(wr_s4), .m_readdata(rd_s4),
        .m_readdatavalid(rdv_s4), .grant(gnt_s4), .sram_address(addr_s4),
        .sram_data(sd_s4), .sram_ce_n(ce_s4), .sram_oe_n(oe_s4), .sram_we_n(we_s4),
        .sram_be_n(be_s4));

    sram_arb_multi #(.NUM_CH(3), .MODE(0), .WAIT_CYCLES(1)) u_s3 (
        .clock(clock), .reset_n(reset_n), .sel(sel), .m_address(m_address[59:0]),
        .m_byteenable(m_byteenable[5:0]), .m_read(m_read[2:0]), .m_write(m_write[2:0]),
        .m_writedata(m_writedata[47:0]), .m_waitrequest(wr_s3), .m_readdata(rd_s3),
        .m_readdatavalid(rdv_s3), .grant(gnt_s3), .sram_address(addr_s3),
        .sram_data(sd_s3), .sram_ce_n(ce_s3), .sram_oe_n(oe_s3), .sram_we_n(we_s3),
        .sram_be_n(be_s3));

    // Memory model for the RR instance; the others return their address as read data.
    assign sd_rr = (!ce_rr && !oe_rr) ? mem[addr_rr[5:0]] : 16'hzzzz;
    assign sd_pr = (!ce_pr && !oe_pr) ? addr_pr[15:0] : 16'hzzzz;
    assign sd_s4 = (!ce_s4 && !oe_s4) ? addr_s4[15:0] : 16'hzzzz;
    assign sd_s3 = (!ce_s3 && !oe_s3) ? addr_s3[15:0] : 16'hzzzz;

    always @(negedge clock)
        if (!ce_rr && !we_rr)
            for (int b = 0; b < 2; b++)
                if (!be_rr[b]) mem[addr_rr[5:0]][b*8 +: 8] <= sd_rr[b*8 +: 8];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_rst();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish, limit 50000");
        $fatal(1);
    end

    initial begin
        sel = 2'd0; m_address = '0; m_byteenable = '1;
        m_read = '0; m_write = '0; m_writedata = '0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        mem[13] = 16'h5A5A;   // 0x0ABCD aliases here
        mem[16] = 16'h7777;
        mem[4]  = 16'hAAAA;

        // reset state
        #12;
        chk("rst_wr",   64'(wr_rr),  64'(4'hF));
        chk("rst_rdv",  64'(rdv_rr), 64'(4'h0));
        chk("rst_gnt",  64'(gnt_rr), 64'(4'h0));
        chk("rst_rd",   64'(rd_rr),  64'(16'h0));
        chk("rst_ctl",  64'({ce_rr, oe_rr, we_rr, be_rr}), 64'(5'b11111));
        chk("rst_addr", 64'(addr_rr), 64'(20'h0));
        reset_n = 1'b1;
        tick();

        // single read ch2
        m_address[40 +: 20] = 20'h0ABCD;
        m_read = 4'b0100;
        chk("rd_c0_oe", 64'(oe_rr), 64'(1'b1));
        tick();
        chk("rd_c1_gnt",  64'(gnt_rr),  64'(4'b0100));
        chk("rd_c1_oe",   64'(oe_rr),   64'(1'b0));
        chk("rd_c1_addr", 64'(addr_rr), 64'(20'h0ABCD));
        chk("rd_c1_wr",   64'(wr_rr),   64'(4'hF));
        tick();
        chk("rd_c2_wr", 64'(wr_rr), 64'(4'b1011));
        chk("rd_c2_oe", 64'(oe_rr), 64'(1'b0));
        m_read = '0;
        tick();
        chk("rd_c3_rdv", 64'(rdv_rr), 64'(4'b0100));
        chk("rd_c3_rd",  64'(rd_rr),  64'(16'h5A5A));
        chk("rd_c3_oe",  64'(oe_rr),  64'(1'b1));
        tick();
        chk("rd_c4_gnt", 64'(gnt_rr), 64'(4'h0));
        chk("rd_c4_rdv", 64'(rdv_rr), 64'(4'h0));

        // byte write ch1, upper byte only
        m_address[20 +: 20] = 20'h00004;
        m_writedata[16 +: 16] = 16'h1234;
        m_byteenable[2 +: 2] = 2'b10;
        m_write = 4'b0010;
        tick();
        chk("bw_c1_we",  64'(we_rr), 64'(1'b0));
        chk("bw_c1_be",  64'(be_rr), 64'(2'b01));
        chk("bw_c1_dat", 64'(sd_rr), 64'(16'h1234));
        tick();
        chk("bw_c2_we", 64'(we_rr), 64'(1'b0));
        chk("bw_c2_wr", 64'(wr_rr), 64'(4'b1101));
        m_write = '0;
        tick();
        chk("bw_c3_we", 64'(we_rr), 64'(1'b1));
        tick();
        m_byteenable[2 +: 2] = 2'b11;
        m_read = 4'b0010;
        tick(2);
        chk("bw_rb_wr", 64'(wr_rr), 64'(4'b1101));
        m_read = '0;
        tick();
        chk("bw_rb_rdv", 64'(rdv_rr), 64'(4'b0010));
        chk("bw_rb_rd",  64'(rd_rr),  64'(16'h12AA));
        tick();

        // reset in the middle of a write
        m_address[0 +: 20] = 20'h00010;
        m_writedata[0 +: 16] = 16'hBEEF;
        m_write = 4'b0001;
        tick();
        chk("mr_c1_we",  64'(we_rr),  64'(1'b0));
        chk("mr_c1_gnt", 64'(gnt_rr), 64'(4'b0001));
        #1 reset_n = 1'b0;
        #1;
        chk("mr_we",   64'(we_rr),  64'(1'b1));
        chk("mr_ce",   64'(ce_rr),  64'(1'b1));
        chk("mr_wr",   64'(wr_rr),  64'(4'hF));
        chk("mr_gnt",  64'(gnt_rr), 64'(4'h0));
        chk("mr_rd",   64'(rd_rr),  64'(16'h0));
        chk("mr_addr", 64'(addr_rr), 64'(20'h0));
        chk("mr_be",   64'(be_rr),  64'(2'b11));
        m_write = '0;
        #1 reset_n = 1'b1;
        tick();
        m_read = 4'b0001;
        tick(2);
        chk("mr_rb_wr", 64'(wr_rr), 64'(4'b1110));
        m_read = '0;
        tick();
        chk("mr_rb_rdv", 64'(rdv_rr), 64'(4'b0001));
        chk("mr_rb_rd",  64'(rd_rr),  64'(16'h7777));
        tick();

        // all channels reading continuously: RR rotates, PRIO sticks to ch0
        pulse_rst();
        m_read = 4'b1111;
        tick();
        for (int k = 0; k < 6; k++) begin
            chk("rr_gnt", 64'(gnt_rr), 64'(1 << (k % 4)));
            chk("pr_gnt", 64'(gnt_pr), 64'(4'b0001));
            tick();
            chk("rr_wr", 64'(wr_rr), 64'(4'hF ^ (1 << (k % 4))));
            tick(2);
            chk("rr_idle", 64'(gnt_rr), 64'(4'h0));
            tick();
        end
        m_read = '0;
        tick(4);

        // three-channel instance, sel beyond range
        pulse_rst();
        sel = 2'd3;
        m_read = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("s3_gnt", 64'(gnt_s3), 64'(3'b000));
            chk("s3_ce",  64'(ce_s3),  64'(1'b1));
            chk("s3_wr",  64'(wr_s3),  64'(3'b111));
        end
        m_read = '0;
        tick();
        pulse_rst();

        // sel mode: ch3 served, sel moved to 1 mid-access
        m_address[20 +: 20] = 20'h00321;
        m_address[60 +: 20] = 20'h00777;
        sel = 2'd3;
        m_read = 4'b1010;
        tick();
        chk("s4_c1_gnt", 64'(gnt_s4), 64'(4'b1000));
        chk("s4_c1_wr",  64'(wr_s4),  64'(4'hF));
        sel = 2'd1;
        tick();
        chk("s4_c2_wr", 64'(wr_s4), 64'(4'b0111));
        m_read = 4'b0010;
        tick();
        chk("s4_c3_rdv", 64'(rdv_s4), 64'(4'b1000));
        chk("s4_c3_rd",  64'(rd_s4),  64'(16'h0777));
        chk("s4_c3_wr",  64'(wr_s4),  64'(4'hF));
        tick();
        chk("s4_c4_gnt", 64'(gnt_s4), 64'(4'h0));
        tick();
        chk("s4_c5_gnt", 64'(gnt_s4), 64'(4'b0010));
        tick();
        chk("s4_c6_wr", 64'(wr_s4), 64'(4'b1101));
        m_read = '0;
        tick();
        chk("s4_c7_rdv", 64'(rdv_s4), 64'(4'b0010));
        chk("s4_c7_rd",  64'(rd_s4),  64'(16'h0321));
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
